// File: rtl/primitive_calculator.sv
// Four-function hex calculator: encoder/button conditioning, entry FSM,
// 8-bit registered result and a two-digit multiplexed seven-segment display.
module primitive_calculator #(
  parameter int DEBOUNCE_LEN = 4,
  parameter int REFRESH_DIV  = 16
) (
  input  logic       clk,
  input  logic       rstb,
  input  logic       select,
  input  logic       restart,
  input  logic       rotary_a,
  input  logic       rotary_b,
  output logic [6:0] seven_segment_out,
  output logic       seven_segment_digit,
  output logic       led_flag,
  output logic       sync
);
  localparam int DCW = $clog2(DEBOUNCE_LEN) + 1;
  localparam int RCW = $clog2(REFRESH_DIV);

  typedef enum logic [1:0] {ENTER_A, ENTER_OP, ENTER_B, SHOW_RESULT} state_t;

  state_t state_q, state_d;
  logic [3:0] s1_q, s2_q;          // {rotary_b, rotary_a, restart, select}
  logic       ra_prev_q;
  logic [1:0] acc_q, acc_d;        // debounced {restart, select}
  logic [1:0][DCW-1:0] dcnt_q, dcnt_d;
  logic [1:0] press;
  logic       sel_evt, rst_evt, rot_evt, rot_dn;
  logic [3:0] a_q, a_d, b_q, b_d;
  logic [1:0] op_q, op_d;
  logic [7:0] r_q, r_d, disp_d;
  logic       led_d, sync_d, dig_d;
  logic [RCW-1:0] rcnt_q, rcnt_d;
  logic [3:0] nib_d;
  logic [6:0] seg_d;

  function automatic logic [7:0] calc(input logic [3:0] a, input logic [3:0] b,
                                      input logic [1:0] op);
    case (op)
      2'd0:    calc = {4'h0, a} + {4'h0, b};
      2'd1:    calc = {4'h0, a} - {4'h0, b};
      2'd2:    calc = {4'h0, a} * {4'h0, b};
      default: calc = {4'h0, a & b};
    endcase
  endfunction

  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'h0: font = 7'h3F; 4'h1: font = 7'h06; 4'h2: font = 7'h5B; 4'h3: font = 7'h4F;
      4'h4: font = 7'h66; 4'h5: font = 7'h6D; 4'h6: font = 7'h7D; 4'h7: font = 7'h07;
      4'h8: font = 7'h7F; 4'h9: font = 7'h6F; 4'hA: font = 7'h77; 4'hB: font = 7'h7C;
      4'hC: font = 7'h39; 4'hD: font = 7'h5E; 4'hE: font = 7'h79; default: font = 7'h71;
    endcase
  endfunction

  // Debounce: accept the synced level only after DEBOUNCE_LEN differing cycles
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      acc_d[i]  = acc_q[i];
      dcnt_d[i] = '0;
      if (s2_q[i] != acc_q[i]) begin
        if (dcnt_q[i] == DCW'(DEBOUNCE_LEN - 1)) acc_d[i] = s2_q[i];
        else dcnt_d[i] = dcnt_q[i] + 1'b1;
      end
    end
  end

  assign press   = acc_d & ~acc_q;
  assign sel_evt = press[0];
  assign rst_evt = press[1];
  assign rot_evt = s2_q[2] & ~ra_prev_q;
  assign rot_dn  = s2_q[3];

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      s1_q      <= '0;
      s2_q      <= '0;
      ra_prev_q <= 1'b0;
      acc_q     <= '0;
      dcnt_q    <= '0;
    end else begin
      s1_q      <= {rotary_b, rotary_a, restart, select};
      s2_q      <= s1_q;
      ra_prev_q <= s2_q[2];
      acc_q     <= acc_d;
      dcnt_q    <= dcnt_d;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) state_q <= ENTER_A;
    else       state_q <= state_d;
  end

  // Rotary lands on the current field before select advances, so R sees it
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    r_d     = r_q;
    if (rst_evt) begin
      state_d = ENTER_A;
      a_d     = '0;
      b_d     = '0;
      op_d    = '0;
    end else begin
      if (rot_evt) begin
        case (state_q)
          ENTER_A:  a_d  = rot_dn ? a_q - 4'd1  : a_q + 4'd1;
          ENTER_OP: op_d = rot_dn ? op_q - 2'd1 : op_q + 2'd1;
          ENTER_B:  b_d  = rot_dn ? b_q - 4'd1  : b_q + 4'd1;
          default:  ;
        endcase
      end
      if (sel_evt) begin
        case (state_q)
          ENTER_A:  state_d = ENTER_OP;
          ENTER_OP: state_d = ENTER_B;
          ENTER_B: begin
            state_d = SHOW_RESULT;
            r_d     = calc(a_d, b_d, op_d);
          end
          default: begin
            state_d = ENTER_A;
            a_d     = '0;
            b_d     = '0;
            op_d    = '0;
          end
        endcase
      end
    end
  end

  // Outputs derive from next-state values so segments and digit stay aligned
  always_comb begin
    led_d  = (state_d == SHOW_RESULT) && (op_d == 2'd1) && (a_d < b_d);
    sync_d = (state_d == SHOW_RESULT) && (state_q != SHOW_RESULT);
    case (state_d)
      ENTER_A:  disp_d = {4'h0, a_d};
      ENTER_OP: disp_d = {6'h00, op_d};
      ENTER_B:  disp_d = {4'h0, b_d};
      default:  disp_d = r_d;
    endcase
    rcnt_d = (rcnt_q == RCW'(REFRESH_DIV - 1)) ? '0 : rcnt_q + 1'b1;
    dig_d  = (rcnt_q == RCW'(REFRESH_DIV - 1)) ? ~seven_segment_digit : seven_segment_digit;
    nib_d  = dig_d ? disp_d[7:4] : disp_d[3:0];
    seg_d  = font(nib_d);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      a_q                 <= '0;
      b_q                 <= '0;
      op_q                <= '0;
      r_q                 <= '0;
      rcnt_q              <= '0;
      seven_segment_digit <= 1'b0;
      seven_segment_out   <= 7'h3F;
      led_flag            <= 1'b0;
      sync                <= 1'b0;
    end else begin
      a_q                 <= a_d;
      b_q                 <= b_d;
      op_q                <= op_d;
      r_q                 <= r_d;
      rcnt_q              <= rcnt_d;
      seven_segment_digit <= dig_d;
      seven_segment_out   <= seg_d;
      led_flag            <= led_d;
      sync                <= sync_d;
    end
  end
endmodule

// File: tb/tb_primitive_calculator.sv
// Bench for primitive_calculator: fixed vectors, corner sequences and random
// encoder/button activity checked against an event-level calculator model.
module tb_primitive_calculator;
  logic       clk = 1'b0;
  logic       rstb = 1'b0;
  logic       select = 1'b0, restart = 1'b0, rotary_a = 1'b0, rotary_b = 1'b0;
  logic [6:0] seg;
  logic       dig, led, syn;

  primitive_calculator dut (
    .clk(clk), .rstb(rstb), .select(select), .restart(restart),
    .rotary_a(rotary_a), .rotary_b(rotary_b),
    .seven_segment_out(seg), .seven_segment_digit(dig),
    .led_flag(led), .sync(syn)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;
  int sync_cnt = 0, wide_cnt = 0;
  logic syn_prev = 1'b0;
  logic [6:0] FONT [16];

  always @(posedge clk) begin
    if (syn) sync_cnt++;
    if (syn && syn_prev) wide_cnt++;
    syn_prev <= syn;
  end

  // Model: state 0=A entry, 1=op entry, 2=B entry, 3=result shown
  int ms = 0, ma = 0, mb = 0, mop = 0, mr = 0, exp_sync = 0;

  task automatic m_rot(input bit dn);
    case (ms)
      0: ma = (ma + (dn ? 15 : 1)) % 16;
      1: mop = (mop + (dn ? 3 : 1)) % 4;
      2: mb = (mb + (dn ? 15 : 1)) % 16;
      default: ;
    endcase
  endtask

  task automatic m_clear();
    ms = 0; ma = 0; mb = 0; mop = 0;
  endtask

  task automatic m_sel();
    case (ms)
      0: ms = 1;
      1: ms = 2;
      2: begin
        ms = 3;
        case (mop)
          0: mr = ma + mb;
          1: mr = (ma - mb + 256) % 256;
          2: mr = ma * mb;
          default: mr = ma & mb;
        endcase
        exp_sync++;
      end
      default: m_clear();
    endcase
  endtask

  function automatic int m_disp();
    case (ms)
      0: return ma;
      1: return mop;
      2: return mb;
      default: return mr;
    endcase
  endfunction

  task automatic cmp(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic detent(input bit dn);
    rotary_b = dn;
    repeat (2) @(negedge clk);
    rotary_a = 1'b1;
    repeat (4) @(negedge clk);
    rotary_a = 1'b0;
    repeat (4) @(negedge clk);
    rotary_b = 1'b0;
    m_rot(dn);
  endtask

  task automatic detents(input int n, input bit dn);
    for (int i = 0; i < n; i++) detent(dn);
  endtask

  task automatic press_sel(input int len);
    select = 1'b1;
    repeat (len) @(negedge clk);
    select = 1'b0;
    repeat (10) @(negedge clk);
    if (len >= 4) m_sel();
  endtask

  task automatic press_rst();
    restart = 1'b1;
    repeat (10) @(negedge clk);
    restart = 1'b0;
    repeat (10) @(negedge clk);
    m_clear();
  endtask

  task automatic sample(output logic [6:0] lo, output logic [6:0] hi, output bit ok);
    bit g0 = 0, g1 = 0;
    lo = '0; hi = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!dig) begin lo = seg; g0 = 1; end
      else      begin hi = seg; g1 = 1; end
    end
    ok = g0 & g1;
  endtask

  task automatic check_exp(input string name, input logic [6:0] elo,
                           input logic [6:0] ehi, input bit eled);
    logic [6:0] lo, hi;
    bit ok;
    sample(lo, hi, ok);
    cmp({name, " both digits seen"}, int'(ok), 1);
    cmp({name, " low digit"}, int'(lo), int'(elo));
    cmp({name, " high digit"}, int'(hi), int'(ehi));
    cmp({name, " led_flag"}, int'(led), int'(eled));
    cmp({name, " sync count"}, sync_cnt, exp_sync);
  endtask

  task automatic check_model(input string name);
    int d = m_disp();
    check_exp(name, FONT[d % 16], FONT[d / 16], (ms == 3) && (mop == 1) && (ma < mb));
  endtask

  typedef struct {
    int a; int op; int b;
    logic [6:0] lo; logic [6:0] hi; bit led;
  } vec_t;

  vec_t vecs [6];

  initial begin
    FONT = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    vecs[0] = '{5, 0, 3, 7'h7F, 7'h3F, 1'b0};   // 8
    vecs[1] = '{2, 1, 5, 7'h5E, 7'h71, 1'b1};   // FD
    vecs[2] = '{15, 2, 15, 7'h06, 7'h79, 1'b0}; // E1
    vecs[3] = '{15, 3, 9, 7'h6F, 7'h3F, 1'b0};  // 09
    vecs[4] = '{0, 1, 1, 7'h71, 7'h71, 1'b1};   // FF
    vecs[5] = '{9, 1, 3, 7'h7D, 7'h3F, 1'b0};   // 06

    repeat (5) @(negedge clk);
    cmp("reset seg", int'(seg), 'h3F);
    cmp("reset digit", int'(dig), 0);
    cmp("reset led", int'(led), 0);
    cmp("reset sync", int'(syn), 0);
    @(negedge clk) rstb = 1'b1;

    begin : refresh_period
      logic d0;
      int n = 0;
      d0 = dig;
      for (int i = 0; i < 40 && dig == d0; i++) @(negedge clk);
      d0 = dig;
      while (dig == d0 && n < 40) begin @(negedge clk); n++; end
      cmp("digit refresh period", n, 16);
    end
    check_exp("after reset", 7'h3F, 7'h3F, 1'b0);

    for (int v = 0; v < 6; v++) begin
      press_rst();
      if (vecs[v].a == 15) detent(1'b1); else detents(vecs[v].a, 1'b0);
      press_sel(10);
      detents(vecs[v].op, 1'b0);
      press_sel(10);
      if (vecs[v].b == 15) detent(1'b1); else detents(vecs[v].b, 1'b0);
      press_sel(10);
      check_exp($sformatf("vector %0d", v), vecs[v].lo, vecs[v].hi, vecs[v].led);
      press_sel(10);
      check_model($sformatf("vector %0d back to A", v));
    end

    // Debounce: short glitch ignored, long press advances once
    press_rst();
    detent(1'b0);
    check_model("debounce pre");
    press_sel(3);
    check_model("debounce glitch");
    press_sel(10);
    detents(2, 1'b0);
    check_model("debounce op");
    press_sel(10);
    detents(3, 1'b0);
    press_sel(10);
    check_model("debounce result");

    // Restart together with select while entering B
    press_rst();
    detents(9, 1'b0);
    press_sel(10);
    press_sel(10);
    detent(1'b0);
    select = 1'b1; restart = 1'b1;
    repeat (10) @(negedge clk);
    select = 1'b0; restart = 1'b0;
    repeat (10) @(negedge clk);
    m_clear();
    check_exp("restart+select", 7'h3F, 7'h3F, 1'b0);
    detents(5, 1'b0);
    check_exp("restart then A=5", 7'h6D, 7'h3F, 1'b0);

    for (int k = 0; k < 40; k++) begin
      int r = $urandom_range(0, 9);
      if (r < 4)      detent(1'b0);
      else if (r < 6) detent(1'b1);
      else if (r < 9) press_sel(4 + $urandom_range(0, 8));
      else            press_rst();
      check_model($sformatf("random step %0d", k));
    end

    cmp("sync pulses one cycle wide", wide_cnt, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
